// File: rtl/morse_pkg.sv
// Shared constants for the Morse player: timing defaults, symbol-code ranges
// and the level-5 pattern table used by the keying FSM.
package morse_pkg;

    localparam int DOT_T_DEF    = 1;
    localparam int DASH_T_DEF   = 3;
    localparam int ELEM_GAP_DEF = 1;
    localparam int SYM_GAP_DEF  = 3;

    localparam int MAX_SYMS = 8;
    localparam int CODE_W   = 6;

    localparam logic [5:0] CODE_EMPTY_LO = 6'd0;
    localparam logic [5:0] CODE_EMPTY_HI = 6'd63;
    localparam logic [5:0] CODE_HEAP_MAX = 6'd30;
    localparam logic [5:0] CODE_L5_BASE  = 6'd31;

    // Level-5 patterns, MSB first, 0=dot 1=dash. Entries 0..9 are the digit
    // shapes 5,4,3,2,1,0,6,7,8,9; the rest are the remaining 5-element shapes
    // in ascending order.
    function automatic logic [4:0] l5_pattern(input logic [4:0] idx);
        logic [4:0] p;
        case (idx)
            5'd0:  p = 5'b00000;
            5'd1:  p = 5'b00001;
            5'd2:  p = 5'b00011;
            5'd3:  p = 5'b00111;
            5'd4:  p = 5'b01111;
            5'd5:  p = 5'b11111;
            5'd6:  p = 5'b10000;
            5'd7:  p = 5'b11000;
            5'd8:  p = 5'b11100;
            5'd9:  p = 5'b11110;
            5'd10: p = 5'b00010;
            5'd11: p = 5'b00100;
            5'd12: p = 5'b00101;
            5'd13: p = 5'b00110;
            5'd14: p = 5'b01000;
            5'd15: p = 5'b01001;
            5'd16: p = 5'b01010;
            5'd17: p = 5'b01011;
            5'd18: p = 5'b01100;
            5'd19: p = 5'b01101;
            5'd20: p = 5'b01110;
            5'd21: p = 5'b10001;
            5'd22: p = 5'b10010;
            5'd23: p = 5'b10011;
            5'd24: p = 5'b10100;
            5'd25: p = 5'b10101;
            5'd26: p = 5'b10110;
            5'd27: p = 5'b10111;
            5'd28: p = 5'b11001;
            5'd29: p = 5'b11010;
            5'd30: p = 5'b11011;
            default: p = 5'b11101;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_pattern_rom.sv
// Combinational symbol decoder: 6-bit code -> element count, right-aligned
// pattern (MSB first, 0=dot 1=dash) and an empty flag.
module morse_pattern_rom
    import morse_pkg::*;
(
    input  logic [5:0] code,
    output logic [2:0] count,
    output logic [4:0] pattern,
    output logic       empty
);

    logic [4:0] heap_pos;

    // code+1 fits in 5 bits for every heap code; its top set bit is the level
    assign heap_pos = code[4:0] + 5'd1;

    always_comb begin
        count   = 3'd0;
        pattern = 5'd0;
        empty   = 1'b0;
        if (code == CODE_EMPTY_LO || code == CODE_EMPTY_HI) begin
            empty = 1'b1;
        end else if (code <= CODE_HEAP_MAX) begin
            if (heap_pos[4]) begin
                count   = 3'd4;
                pattern = {1'b0, heap_pos[3:0]};
            end else if (heap_pos[3]) begin
                count   = 3'd3;
                pattern = {2'b0, heap_pos[2:0]};
            end else if (heap_pos[2]) begin
                count   = 3'd2;
                pattern = {3'b0, heap_pos[1:0]};
            end else begin
                count   = 3'd1;
                pattern = {4'b0, heap_pos[0]};
            end
        end else begin
            // 5-bit wrap makes code 31 -> 0, 32 -> 1, ... 62 -> 31
            count   = 3'd5;
            pattern = l5_pattern(code[4:0] - CODE_L5_BASE[4:0]);
        end
    end

endmodule

// File: rtl/morse_player.sv
// Plays a buffer of up to eight Morse symbol codes as a tone on/off sequence
// timed by an external tick strobe.
module morse_player
    import morse_pkg::*;
#(
    parameter int DOT_T    = DOT_T_DEF,
    parameter int DASH_T   = DASH_T_DEF,
    parameter int ELEM_GAP = ELEM_GAP_DEF,
    parameter int SYM_GAP  = SYM_GAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        tick,
    input  logic [47:0] shown,
    input  logic [3:0]  len,
    output logic        tone,
    output logic        busy,
    output logic [2:0]  sym_idx,
    output logic        done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] MARK = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] SGAP = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] DOT_L  = CNT_W'(DOT_T);
    localparam logic [CNT_W-1:0] DASH_L = CNT_W'(DASH_T);
    localparam logic [CNT_W-1:0] EGAP_L = CNT_W'(ELEM_GAP);
    localparam logic [CNT_W-1:0] SGAP_L = CNT_W'(SYM_GAP);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [47:0]      shown_l;
    logic [3:0]       len_l;
    logic [3:0]       len_eff;
    logic [4:0]       shreg;
    logic [2:0]       elem_left;
    logic             fin_after;
    logic             last_sym;
    logic [CNT_W-1:0] mark_len;

    logic [5:0] codes [MAX_SYMS];
    logic [5:0] cur_code;
    logic [2:0] rom_count;
    logic [4:0] rom_pattern;
    logic       rom_empty;

    always_comb begin
        for (int k = 0; k < MAX_SYMS; k++) begin
            codes[k] = shown_l[CODE_W*k +: CODE_W];
        end
    end

    assign cur_code = codes[sym_idx];

    morse_pattern_rom u_rom (
        .code    (cur_code),
        .count   (rom_count),
        .pattern (rom_pattern),
        .empty   (rom_empty)
    );

    assign len_eff  = (len > 4'd8) ? 4'd8 : len;
    assign last_sym = ({1'b0, sym_idx} == (len_l - 4'd1));
    assign cnt_nxt  = cnt + 1'b1;
    // shreg is left-aligned, so bit 4 is always the element being played
    assign mark_len = shreg[4] ? DASH_L : DOT_L;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shown_l   <= '0;
            len_l     <= '0;
            sym_idx   <= '0;
            shreg     <= '0;
            elem_left <= '0;
            fin_after <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shown_l <= shown;
                        len_l   <= len_eff;
                        sym_idx <= '0;
                        cnt     <= '0;
                        state   <= (len_eff == 4'd0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (rom_empty) begin
                        // an empty last symbol still plays its silence, then finishes
                        fin_after <= last_sym;
                        if (!last_sym) sym_idx <= sym_idx + 3'd1;
                        state <= SGAP;
                    end else begin
                        shreg     <= rom_pattern << (3'd5 - rom_count);
                        elem_left <= rom_count;
                        state     <= MARK;
                    end
                end
                MARK: begin
                    if (tick) begin
                        if (cnt_nxt >= mark_len) begin
                            cnt       <= '0;
                            shreg     <= shreg << 1;
                            elem_left <= elem_left - 3'd1;
                            if (elem_left > 3'd1) begin
                                state <= GAP;
                            end else if (last_sym) begin
                                state <= FIN;
                            end else begin
                                fin_after <= 1'b0;
                                sym_idx   <= sym_idx + 3'd1;
                                state     <= SGAP;
                            end
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_nxt >= EGAP_L) begin
                            cnt   <= '0;
                            state <= MARK;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                SGAP: begin
                    if (tick) begin
                        if (cnt_nxt >= SGAP_L) begin
                            cnt   <= '0;
                            state <= fin_after ? FIN : LOAD;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // abort silences the output in the same cycle it is seen
    assign tone = (state == MARK) && !abort;
    assign busy = (state != IDLE);
    assign done = (state == FIN) && !abort;

endmodule

// File: tb/tb_morse_player.sv
// Directed scoreboard bench for morse_player: expected per-cycle outputs are
// queued when playback is requested and compared as the DUT runs.
module tb_morse_player;

    localparam int T_DOT  = 1;
    localparam int T_DASH = 3;
    localparam int T_EGAP = 1;
    localparam int T_SGAP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tick = 1'b1;
    logic [47:0] shown = '0;
    logic [3:0]  len = '0;
    logic        tone;
    logic        busy;
    logic [2:0]  sym_idx;
    logic        done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       tone;
        logic       busy;
        logic       done;
        logic       chk_idx;
        logic [2:0] idx;
    } exp_t;

    exp_t sbq[$];

    morse_player dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .tick    (tick),
        .shown   (shown),
        .len     (len),
        .tone    (tone),
        .busy    (busy),
        .sym_idx (sym_idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic string dec(input int code);
        string s;
        int v, lvl, b;
        s = "";
        if (code == 0 || code == 63) return s;
        if (code <= 30) begin
            v   = code + 1;
            lvl = $clog2(v + 1) - 1;
            b   = v - (1 << lvl);
            for (int i = lvl - 1; i >= 0; i--) begin
                if (((b >> i) & 1) != 0) s = {s, "-"};
                else s = {s, "."};
            end
            return s;
        end
        case (code)
            31: s = ".....";
            32: s = "....-";
            33: s = "...--";
            default: s = "?????";
        endcase
        return s;
    endfunction

    function automatic void push(input logic t, input logic b, input logic d,
                                 input logic ci, input int idx);
        exp_t e;
        e.tone = t; e.busy = b; e.done = d; e.chk_idx = ci; e.idx = 3'(idx);
        sbq.push_back(e);
    endfunction

    function automatic void build(input logic [47:0] sh, input logic [3:0] ln);
        int n;
        string s;
        n = (ln > 8) ? 8 : int'(ln);
        if (n == 0) begin
            push(0, 1, 1, 0, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            s = dec(int'(sh[6*k +: 6]));
            push(0, 1, 0, 1, k);
            for (int e = 0; e < s.len(); e++) begin
                for (int c = 0; c < ((s[e] == "-") ? T_DASH : T_DOT); c++) push(1, 1, 0, 1, k);
                if (e < s.len() - 1)
                    for (int c = 0; c < T_EGAP; c++) push(0, 1, 0, 0, 0);
            end
            if (k == n - 1 && s.len() != 0) begin
                push(0, 1, 1, 0, 0);
            end else begin
                for (int c = 0; c < T_SGAP; c++) push(0, 1, 0, 0, 0);
                if (k == n - 1) push(0, 1, 1, 0, 0);
            end
        end
    endfunction

    // stop_at < 0 plays to completion; pause_at stalls tick inside a mark;
    // restart_at pulses start with a different buffer mid-playback
    task automatic play(input string tag, input logic [47:0] sh, input logic [3:0] ln,
                        input int stop_at, input int pause_at, input int restart_at);
        exp_t e;
        int i;
        shown = sh;
        len   = ln;
        start = 1'b1;
        sbq.delete();
        build(sh, ln);
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        while (sbq.size() > 0 && i != stop_at) begin
            e = sbq.pop_front();
            chk({tag, ".tone"}, 8'(tone), 8'(e.tone));
            chk({tag, ".busy"}, 8'(busy), 8'(e.busy));
            chk({tag, ".done"}, 8'(done), 8'(e.done));
            if (e.chk_idx) chk({tag, ".sym_idx"}, 8'(sym_idx), 8'(e.idx));
            if (i == pause_at && e.tone) begin
                tick = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    chk({tag, ".pause_tone"}, 8'(tone), 8'd1);
                end
                tick = 1'b1;
            end
            if (i == restart_at) begin
                start = 1'b1;
                shown = ~sh;
                len   = 4'd8;
            end
            @(posedge clk); #1;
            start = 1'b0;
            i++;
        end
        if (stop_at < 0) begin
            chk({tag, ".end_busy"}, 8'(busy), 8'd0);
            chk({tag, ".end_done"}, 8'(done), 8'd0);
        end
    endtask

    logic [47:0] sh;

    initial begin
        #1;
        chk("rst.tone", 8'(tone), 8'd0);
        chk("rst.busy", 8'(busy), 8'd0);
        chk("rst.sym_idx", 8'(sym_idx), 8'd0);
        chk("rst.done", 8'(done), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        play("E", 48'd1, 4'd1, -1, -1, -1);
        play("A", 48'd4, 4'd1, -1, 1, -1);
        play("TE", {36'd0, 6'd1, 6'd2}, 4'd2, -1, -1, -1);
        play("L5_31", 48'd31, 4'd1, -1, -1, -1);
        play("L5_33_32", {36'd0, 6'd32, 6'd33}, 4'd2, -1, -1, -1);
        play("EMPTY0", 48'd0, 4'd1, -1, -1, -1);
        play("MIXED", {30'd0, 6'd1, 6'd63, 6'd4}, 4'd3, -1, -1, -1);

        // abort during the dash of A
        play("ABORT", 48'd4, 4'd1, 3, -1, -1);
        chk("abort.pre_tone", 8'(tone), 8'd1);
        abort = 1'b1;
        #1;
        chk("abort.tone_now", 8'(tone), 8'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort.busy", 8'(busy), 8'd0);
        chk("abort.done", 8'(done), 8'd0);
        chk("abort.tone", 8'(tone), 8'd0);
        @(posedge clk); #1;
        chk("abort.done2", 8'(done), 8'd0);
        play("RESTART", 48'd4, 4'd1, -1, -1, -1);

        play("LEN0", 48'd1, 4'd0, -1, -1, -1);

        for (int k = 0; k < 8; k++) sh[6*k +: 6] = 6'($urandom_range(1, 30));
        play("LEN12", sh, 4'd12, -1, 4, 2);
        for (int k = 0; k < 8; k++) sh[6*k +: 6] = 6'($urandom_range(1, 30));
        play("LEN9", sh, 4'd9, -1, -1, -1);

        // reset while the second symbol's dash is sounding
        play("RSTMID", {36'd0, 6'd2, 6'd4}, 4'd2, 10, -1, -1);
        chk("rstmid.pre_tone", 8'(tone), 8'd1);
        chk("rstmid.pre_idx", 8'(sym_idx), 8'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.tone", 8'(tone), 8'd0);
        chk("rstmid.busy", 8'(busy), 8'd0);
        chk("rstmid.sym_idx", 8'(sym_idx), 8'd0);
        chk("rstmid.done", 8'(done), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.after_done", 8'(done), 8'd0);
        chk("rstmid.after_busy", 8'(busy), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
